// File: rtl/tick_period_meter_pkg.sv
// Shared types and constants for the tick period meter.
package tick_period_meter_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FIRST = 2'd1,
      MEASURE    = 2'd2
   } state_t;

   localparam int unsigned CLK_HZ = 100_000_000;

   // One second of system clock.
   localparam int unsigned DEFAULT_TIMEOUT_TICKS = CLK_HZ;

endpackage

// File: rtl/tick_period_meter_sync.sv
// Multi-flop synchroniser for an asynchronous input, followed by a
// single-cycle rising-edge detector.
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   always_comb begin
      rise = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

endmodule

// File: rtl/tick_period_meter.sv
// Measures clk cycles between consecutive rising edges of pulse_in, with a
// valid strobe per measurement and a timeout strobe when edges stop.
module tick_period_meter
   import tick_period_meter_pkg::*;
#(
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] period,
   output logic             valid,
   output logic             timeout,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_d;
   logic             valid_d, timeout_d;
   logic             edge_det;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (pulse_in),
      .rise (edge_det)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         period  <= '0;
         valid   <= 1'b0;
         timeout <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         period  <= period_d;
         valid   <= valid_d;
         timeout <= timeout_d;
         busy    <= (state_d == MEASURE);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period;
      valid_d   = 1'b0;
      timeout_d = 1'b0;

      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_d   = '0;
               state_d = WAIT_FIRST;
            end
            WAIT_FIRST: begin
               if (edge_det) begin
                  cnt_d   = '0;
                  state_d = MEASURE;
               end
            end
            MEASURE: begin
               // An edge coinciding with the last count still yields a
               // measurement of exactly TIMEOUT_TICKS.
               if (edge_det) begin
                  period_d = cnt_q + CNT_ONE;
                  valid_d  = 1'b1;
                  cnt_d    = '0;
               end else if (cnt_q == CNT_LAST) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = WAIT_FIRST;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: table-driven pulse trains plus
// hand-written enable, reset and asynchronous-phase sequences.
module tb_tick_period_meter;

   localparam int unsigned CNT_W   = 32;
   localparam int unsigned TIMEOUT = 1000;

   logic             clk;
   logic             rst;
   logic             en;
   logic             pulse_in;
   logic [CNT_W-1:0] period;
   logic             valid;
   logic             timeout;
   logic             busy;

   tick_period_meter #(
      .CNT_W         (CNT_W),
      .SYNC_STAGES   (2),
      .TIMEOUT_TICKS (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .pulse_in (pulse_in),
      .period   (period),
      .valid    (valid),
      .timeout  (timeout),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned gap;
      int unsigned width;
      int unsigned n;
      int unsigned tail;
      int unsigned exp_valid;
      int unsigned exp_to;
      int unsigned exp_min;
      int unsigned exp_max;
   } vec_t;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   int unsigned v_cnt, t_cnt, ovl_cnt, dbl_cnt;
   logic [CNT_W-1:0] p_min, p_max, p_last;
   logic prev_v, prev_t;

   initial begin
      ovl_cnt = 0;
      dbl_cnt = 0;
      prev_v  = 1'b0;
      prev_t  = 1'b0;
   end

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         v_cnt++;
         p_last = period;
         if (period < p_min) p_min = period;
         if (period > p_max) p_max = period;
         if (prev_v === 1'b1) dbl_cnt++;
      end
      if (timeout === 1'b1) begin
         t_cnt++;
         if (prev_t === 1'b1) dbl_cnt++;
      end
      if (valid === 1'b1 && timeout === 1'b1) ovl_cnt++;
      prev_v = valid;
      prev_t = timeout;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cycles(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mon();
      v_cnt  = 0;
      t_cnt  = 0;
      p_min  = '1;
      p_max  = '0;
      p_last = '0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      en       = 1'b0;
      pulse_in = 1'b0;
      cycles(2);
      rst = 1'b0;
      en  = 1'b1;
      cycles(2);
      clear_mon();
   endtask

   task automatic run_train(input int unsigned gap, input int unsigned width,
                            input int unsigned n, input int unsigned tail);
      for (int unsigned k = 0; k < n; k++) begin
         pulse_in = 1'b1;
         cycles(width);
         pulse_in = 1'b0;
         if (k + 1 < n) cycles(gap - width);
      end
      cycles(tail);
   endtask

   task automatic one_pulse(input int unsigned low_after);
      pulse_in = 1'b1;
      cycles(1);
      pulse_in = 1'b0;
      cycles(low_after);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   vec_t vecs[6];

   initial begin
      time    t0;
      longint tgt;
      int     d;
      int unsigned j;

      vecs[0] = '{gap: 100,  width: 1,    n: 5,  tail: 20, exp_valid: 4, exp_to: 0, exp_min: 100,  exp_max: 100};
      vecs[1] = '{gap: 1000, width: 1,    n: 3,  tail: 20, exp_valid: 2, exp_to: 0, exp_min: 1000, exp_max: 1000};
      vecs[2] = '{gap: 1001, width: 1,    n: 3,  tail: 20, exp_valid: 0, exp_to: 2, exp_min: 32'hFFFF_FFFF, exp_max: 0};
      vecs[3] = '{gap: 2,    width: 1,    n: 10, tail: 20, exp_valid: 9, exp_to: 0, exp_min: 2,    exp_max: 2};
      vecs[4] = '{gap: 2500, width: 2500, n: 1,  tail: 20, exp_valid: 0, exp_to: 1, exp_min: 32'hFFFF_FFFF, exp_max: 0};
      vecs[5] = '{gap: 37,   width: 5,    n: 4,  tail: 20, exp_valid: 3, exp_to: 0, exp_min: 37,   exp_max: 37};

      // Reset state
      do_reset();
      check("rst_period",  period,  0);
      check("rst_valid",   valid,   0);
      check("rst_timeout", timeout, 0);
      check("rst_busy",    busy,    0);

      foreach (vecs[i]) begin
         do_reset();
         run_train(vecs[i].gap, vecs[i].width, vecs[i].n, vecs[i].tail);
         check($sformatf("vec%0d_valid_count", i), v_cnt, vecs[i].exp_valid);
         check($sformatf("vec%0d_timeout_count", i), t_cnt, vecs[i].exp_to);
         check($sformatf("vec%0d_period_min", i), p_min, vecs[i].exp_min);
         check($sformatf("vec%0d_period_max", i), p_max, vecs[i].exp_max);
      end

      // Enable dropped mid-interval
      do_reset();
      one_pulse(36);
      one_pulse(36);
      one_pulse(10);
      check("en_pre_valid_count", v_cnt, 2);
      check("en_pre_busy", busy, 1);
      en = 1'b0;
      cycles(1);
      check("en_busy_fall", busy, 0);
      cycles(4);
      check("en_off_valid_count", v_cnt, 2);
      check("en_off_timeout_count", t_cnt, 0);
      check("en_off_period_hold", period, 37);
      en = 1'b1;
      cycles(21);
      one_pulse(36);
      check("en_rearm_valid_count", v_cnt, 2);
      check("en_rearm_busy", busy, 1);
      one_pulse(10);
      check("en_resume_valid_count", v_cnt, 3);
      check("en_resume_period", p_last, 37);

      // Reset during MEASURE
      do_reset();
      one_pulse(36);
      one_pulse(10);
      check("rstm_pre_period", period, 37);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      check("rstm_period", period,  0);
      check("rstm_valid",  valid,   0);
      check("rstm_timeout", timeout, 0);
      check("rstm_busy",   busy,    0);
      cycles(25);
      one_pulse(36);
      check("rstm_rearm_valid_count", v_cnt, 1);
      one_pulse(10);
      check("rstm_resume_valid_count", v_cnt, 2);
      check("rstm_resume_period", p_last, 37);
      check("rstm_resume_busy", busy, 1);
      check("rstm_timeout_count", t_cnt, 0);

      // Asynchronous edges: nominal 250-cycle period, phase jitter up to
      // +/-0.4 cycle around a clock edge so the sampled cycle moves.
      do_reset();
      t0 = $time;
      for (int k = 0; k < 6; k++) begin
         j   = $urandom_range(0, 7);
         d   = (j < 4) ? int'(j) - 4 : int'(j) - 3;
         tgt = longint'(t0) + 9 + longint'(k) * 2500 + longint'(d);
         #(tgt - longint'($time));
         pulse_in = 1'b1;
         #30;
         pulse_in = 1'b0;
      end
      cycles(25);
      check("async_valid_count", v_cnt, 5);
      check("async_timeout_count", t_cnt, 0);
      check("async_min_in_range", (p_min >= 249 && p_min <= 251), 1);
      check("async_max_in_range", (p_max >= 249 && p_max <= 251), 1);

      check("strobe_overlap", ovl_cnt, 0);
      check("strobe_width",   dbl_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
